// File: rtl/wb_mmio_master.sv
// Wishbone classic single-transfer master: turns a valid/ready command stream
// into one bus cycle per command and returns data/timeout on a response stream.
module wb_mmio_master #(
  parameter int unsigned ADDR_W  = 21,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic [ADDR_W-1:0] ADDR_O,
  output logic [DATA_W-1:0] DAT_O,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic              ACK_I
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cyc_q;
  logic                stb_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dat_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  // Handshake flags are pure state decodes so they react in the same cycle.
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  assign CYC_O     = cyc_q;
  assign STB_O     = stb_q;
  assign WE_O      = we_q;
  assign ADDR_O    = addr_q;
  assign DAT_O     = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            we_q    <= cmd_we;
            addr_q  <= cmd_addr;
            dat_q   <= cmd_wdata;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_BUS;
          end
        end
        S_BUS: begin
          // ACK has priority over an expiry landing on the same edge.
          if (ACK_I) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : DAT_I;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mmio_master.sv
// Scoreboard bench for wb_mmio_master: directed commands against a RAM slave
// with programmable wait states; bus and response monitors check independently.
module tb_wb_mmio_master;
  localparam int unsigned ADDR_W  = 21;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              CLK_I = 1'b0;
  logic              RST_I = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              CYC_O, STB_O, WE_O;
  logic [ADDR_W-1:0] ADDR_O;
  logic [DATA_W-1:0] DAT_O;
  logic [DATA_W-1:0] DAT_I;
  logic              ACK_I;

  wb_mmio_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADDR_O(ADDR_O),
    .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: RAM with programmable wait states, optional never-ACK, stray ACK.
  logic [31:0] mem [0:255];
  int          slave_waits = 0;
  logic        slave_noack = 1'b0;
  logic        stray_ack   = 1'b0;
  int          wait_cnt    = 0;

  assign ACK_I = stray_ack | (CYC_O & STB_O & ~slave_noack & (wait_cnt == slave_waits));
  assign DAT_I = mem[ADDR_O[9:2]];

  always @(posedge CLK_I) begin
    if (CYC_O && STB_O && !ACK_I) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
    if (ACK_I && CYC_O && STB_O && WE_O) mem[ADDR_O[9:2]] <= DAT_O;
  end

  // Expected queues: response {err, rdata}; bus {we, addr, data}.
  logic [32:0] rsp_q [$];
  logic [53:0] bus_q [$];

  // Response monitor: compares on every response handshake.
  always @(negedge CLK_I) begin
    if (!RST_I && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, rsp_valid}, 64'd0);
      end else begin
        logic [32:0] e;
        e = rsp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        check("rsp_err",   64'(rsp_err),   64'(e[32]));
      end
    end
  end

  // Bus monitor: first strobe cycle checks against expectation, later ones check stability.
  int          stb_len = 0;
  int          last_stb_len = 0;
  int          cyc_rises = 0;
  logic        cyc_prev = 1'b0;
  logic [53:0] cur_bus;
  always @(negedge CLK_I) begin
    if (CYC_O && !cyc_prev) cyc_rises++;
    cyc_prev = CYC_O;
    if (CYC_O && STB_O) begin
      if (stb_len == 0) begin
        if (bus_q.size() == 0) begin
          check("unexpected_stb", 64'd1, 64'd0);
          cur_bus = {WE_O, ADDR_O, DAT_O};
        end else begin
          cur_bus = bus_q.pop_front();
          check("bus_fields", 64'({WE_O, ADDR_O, DAT_O}), 64'(cur_bus));
        end
      end else begin
        check("bus_stable", 64'({WE_O, ADDR_O, DAT_O}), 64'(cur_bus));
      end
      stb_len++;
    end else if (stb_len != 0) begin
      last_stb_len = stb_len;
      stb_len = 0;
    end
  end

  // Present a command and return one cycle after it is accepted.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input int waits,
                       input logic noack, input logic exp_err,
                       input logic [DATA_W-1:0] exp_rdata, input bit push_rsp);
    int n;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge CLK_I); #1; n++; end
    if (n >= 200) check("cmd_accept_timeout", 64'd0, 64'd1);
    slave_waits = waits;
    slave_noack = noack;
    bus_q.push_back({we, addr, wdata});
    if (push_rsp) rsp_q.push_back({exp_err, exp_rdata});
    @(posedge CLK_I); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || busy) && n < 300) begin @(posedge CLK_I); #1; n++; end
    if (n >= 300) check("drain_timeout", 64'd0, 64'd1);
    @(posedge CLK_I); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'h1234_5678;   // address 0x100

    repeat (3) @(posedge CLK_I);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_cyc_stb",   64'({CYC_O, STB_O, WE_O}), 64'd0);
    check("rst_addr_dat",  64'({ADDR_O, DAT_O}), 64'd0);
    check("rst_rsp",       64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    RST_I = 1'b0;
    @(posedge CLK_I); #1;

    // Write, zero-wait.
    issue(1'b1, 21'h000C0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wr_cyc_high", 64'({CYC_O, STB_O, WE_O}), 64'h7);
    check("wr_busy",     64'(busy), 64'd1);
    wait_done();
    check("wr_stb_len",  64'(last_stb_len), 64'd1);
    check("wr_mem",      64'(mem[8'h30]), 64'hDEAD_BEEF);

    // Read, 3 wait states.
    issue(1'b0, 21'h00100, 32'h0, 3, 1'b0, 1'b0, 32'h1234_5678, 1'b1);
    wait_done();
    check("rd_stb_len",  64'(last_stb_len), 64'd4);

    // Timeout.
    issue(1'b0, 21'h00200, 32'h0, 0, 1'b1, 1'b1, 32'h0, 1'b1);
    wait_done();
    check("to_stb_len",  64'(last_stb_len), 64'd8);
    check("to_cyc_low",  64'({CYC_O, STB_O}), 64'd0);
    slave_noack = 1'b0;

    // Response backpressure with cmd_valid held.
    rsp_ready = 1'b0;
    issue(1'b0, 21'h000C0, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 21'h00140; cmd_wdata = 32'hCAFE_F00D;
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge CLK_I); #1; n++; end
      check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({rsp_valid, rsp_err, cmd_ready, CYC_O, rsp_rdata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF}));
      @(posedge CLK_I); #1;
    end
    rsp_ready = 1'b1;
    bus_q.push_back({1'b1, 21'h00140, 32'hCAFE_F00D});
    rsp_q.push_back({1'b0, 32'h0});
    @(posedge CLK_I); #1;
    check("bp_not_same_cycle", 64'({cmd_ready, CYC_O, rsp_valid}), 64'b100);
    @(posedge CLK_I); #1;
    check("bp_accepted_next", 64'({cmd_ready, CYC_O}), 64'b01);
    cmd_valid = 1'b0;
    wait_done();
    check("bp_wr_mem", 64'(mem[8'h50]), 64'hCAFE_F00D);

    // Reset in the 2nd BUS cycle of a read.
    issue(1'b0, 21'h00300, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    slave_noack = 1'b0;
    check("rst_mid_cyc",   64'({CYC_O, STB_O}), 64'd0);
    check("rst_mid_ready", 64'({cmd_ready, busy, rsp_valid}), 64'b100);
    stray_ack = 1'b1;
    @(posedge CLK_I); #1;
    stray_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_ack_ignored", 64'({cmd_ready, busy, rsp_valid, CYC_O}), 64'b1000);
      @(posedge CLK_I); #1;
    end

    // Back-to-back alternating write/read with random waits.
    base = cyc_rises;
    for (int i = 0; i < 8; i++) begin
      d = 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
      issue(1'b1, 21'h00200 + 21'(4 * i), d, int'($urandom_range(0, 4)), 1'b0, 1'b0, 32'h0, 1'b1);
      issue(1'b0, 21'h00200 + 21'(4 * i), 32'h0, int'($urandom_range(0, 4)), 1'b0, 1'b0, d, 1'b1);
    end
    wait_done();
    check("b2b_cyc_count", 64'(cyc_rises - base), 64'd16);
    check("rsp_q_empty",   64'(rsp_q.size()), 64'd0);
    check("bus_q_empty",   64'(bus_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_mmio_master.md
Name: wb_mmio_master

Overview:
- Wishbone classic single-transfer bus master (initiator) that drives the MMIO subsystem's Wishbone slave port.
- Converts a valid/ready command stream into one Wishbone read or write cycle per command.
- Returns the result on a valid/ready response stream, with bus-timeout error reporting.
- Sits between a command source (debug bridge, test sequencer, or soft core adapter) and the MMIO system.

Parameters:
- ADDR_W, 21, Wishbone address width; matches the MMIO address width.
- DATA_W, 32, Wishbone data width.
- TIMEOUT, 255, maximum cycles to wait for ACK_I in the bus state; must be >= 1.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  1 = transfer timed out.
- busy  out  1  1 in any state other than IDLE.
- CYC_O  out  1  Wishbone cycle.
- STB_O  out  1  Wishbone strobe.
- WE_O  out  1  Wishbone write enable.
- ADDR_O  out  ADDR_W  Wishbone address.
- DAT_O  out  DATA_W  Wishbone write data.
- DAT_I  in  DATA_W  Wishbone read data.
- ACK_I  in  1  Wishbone acknowledge.

Behaviour:
- Clocking and reset: one clock, CLK_I. Reset is synchronous and active-high on RST_I.
- Reset values:
  - state = IDLE, so cmd_ready = 1.
  - rsp_valid, rsp_err, busy, CYC_O, STB_O, WE_O = 0.
  - ADDR_O, DAT_O, rsp_rdata = 0.
  - Timeout counter = 0.
- All Wishbone outputs and response outputs are registered. cmd_ready and busy are decoded from state.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_we, cmd_addr and cmd_wdata into WE_O, ADDR_O and DAT_O. Set CYC_O = STB_O = 1, clear the counter, go to BUS.
  - CYC_O/STB_O therefore first appear high the cycle after acceptance.
- BUS:
  - cmd_ready = 0. CYC_O, STB_O, WE_O, ADDR_O and DAT_O are held stable until termination.
  - ACK_I sampled high, including in the first BUS cycle (zero-wait slaves):
    - Clear CYC_O/STB_O/WE_O at the next edge.
    - rsp_rdata <= DAT_I if read, else 0.
    - rsp_err <= 0, rsp_valid <= 1, go to RESP.
  - Otherwise the counter increments each cycle. When the counter reaches TIMEOUT-1 without ACK_I:
    - Clear CYC_O/STB_O at the next edge.
    - rsp_rdata <= 0, rsp_err <= 1, rsp_valid <= 1, go to RESP.
  - ACK_I on the same edge as expiry wins: normal completion, err = 0.
  - Counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_err stable.
  - On rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new command is accepted in the rsp_ready cycle. Minimum command-to-command spacing is 3 cycles with a zero-wait slave.
- ACK_I high while not in BUS is ignored.
- DAT_I is sampled only on the ACK edge for reads.
- Latency: command accepted at edge 0 → STB_O high after edge 0 → ACK at edge k (k >= 1) → rsp_valid high after edge k.
- busy = 1 in BUS and RESP.
- Reset asserted mid-BUS or mid-RESP: at the next edge all outputs take their reset values. CYC_O drops immediately and the pending transfer and response are discarded; no response is issued.
- rsp_ready held high outside RESP has no effect.
- cmd_valid held high in BUS/RESP has no effect; the command is not accepted until IDLE.

Test Plan:
- Write, zero-wait slave: cmd_we=1, addr=0x000C0, wdata=0xDEAD_BEEF. Required: CYC/STB/WE high exactly 1 cycle with ADDR_O=0x000C0 and DAT_O=0xDEADBEEF; then rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Read, 3-wait-state slave returning 0x1234_5678 with ACK on the 4th STB cycle. Required: STB high 4 cycles, then rsp_rdata=0x12345678, rsp_err=0; bus signals unchanged during the waits.
- Timeout, TIMEOUT=8, slave never ACKs. Required: STB high exactly 8 cycles, then CYC/STB=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with cmd_valid held high. Required: rsp fields stable, cmd_ready=0; the next command is accepted only in the cycle after the rsp_ready handshake.
- RST_I pulsed for 1 cycle in the 2nd BUS cycle of a read. Required: CYC/STB=0 and cmd_ready=1 after the reset edge; rsp_valid never asserts; a later stray ACK_I is ignored.
- Back-to-back: 16 alternating write/read commands to a RAM-model slave with random waits. Every read returns the previously written value, and no overlapping CYC cycles occur.
